// File: rtl/add_result_buffer.sv
// add_result_buffer: downstream stage of the pipelined N-bit adder.
// Tracks launched operand pairs through a LAT-deep valid delay line and
// captures {add_cout, add_s} when each result emerges from the adder. It
// buffers the results in a DEPTH-entry FIFO and hands them to the consumer.
// Launches are throttled with in_ready so that a capture never meets a
// full FIFO.
//
// Optional feature macro: ADD_RESULT_BUFFER_STATS_EN
//   When defined, the block adds stall_cnt[15:0] and res_cnt[15:0].
//   stall_cnt counts cycles with in_valid=1 and in_ready=0.
//   res_cnt counts pops.
//
// Handshake semantics (both sides):
//   - A transfer happens on a rising clk edge when valid and ready are both 1.
//     This gives launch = in_valid & in_ready and pop = out_valid & out_ready.
//   - in_ready and out_valid are functions of registered state only.
//   - in_ready never depends combinationally on in_valid or out_ready.
//   - out_data is held stable while out_valid=1 and out_ready=0.

module add_result_buffer #(
    parameter int N     = 32,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               add_s,
    input  logic                       add_cout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N:0]                 out_data,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef ADD_RESULT_BUFFER_STATS_EN
    ,
    output logic [15:0]                stall_cnt,
    output logic [15:0]                res_cnt
`endif
);

    // Widths: PW = FIFO pointer, LW = occupancy, CW = occupancy plus in-flight credits.
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(DEPTH + LAT + 1);

    // Valid delay line. Bit i is set when a launch happened i+1 edges ago.
    logic [LAT-1:0] vld_pipe;
    logic [LAT-1:0] vld_next;

    // FIFO storage and pointers.
    logic [N:0]     mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    // Per-cycle events and next-state values.
    logic           launch;
    logic           capture;
    logic           pop;
    logic [LW-1:0]  level_next;
    logic [CW-1:0]  inflight_next;
    logic [CW-1:0]  credit_sum;
    logic           in_ready_next;

    // Outputs taken straight from registered state.
    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];

    // Derive handshake events, next delay line, next level and next credit state.
    always_comb begin
        launch  = in_valid & in_ready;
        capture = vld_pipe[LAT-1];
        pop     = out_valid & out_ready;

        vld_next    = '0;
        vld_next[0] = launch;
        for (int i = 1; i < LAT; i++) begin
            vld_next[i] = vld_pipe[i-1];
        end

        level_next = level;
        case ({capture, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase

        inflight_next = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight_next = inflight_next + CW'(vld_next[i]);
        end

        // Every in-flight launch already owns a FIFO slot. A new launch is
        // allowed only while an unclaimed slot remains after this edge.
        credit_sum    = CW'(level_next) + inflight_next;
        in_ready_next = (credit_sum < CW'(DEPTH));
    end

    // Shift the launch bit through the delay line and register the credit decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            in_ready <= 1'b1;
        end else begin
            vld_pipe <= vld_next;
            in_ready <= in_ready_next;
        end
    end

    // FIFO write on capture, read-pointer advance on pop, and exact occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (capture) begin
                mem[wr_ptr] <= {add_cout, add_s};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level <= level_next;
        end
    end

`ifdef ADD_RESULT_BUFFER_STATS_EN
    // Count stalled launch attempts and accepted results. Both counters wrap at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            res_cnt   <= '0;
        end else begin
            if (in_valid && !in_ready) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (pop) begin
                res_cnt <= res_cnt + 16'd1;
            end
        end
    end
`else
`endif

`ifndef SYNTHESIS
    // A capture into a full FIFO without a same-cycle pop would lose a result.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && (level == LW'(DEPTH)) && !pop))
        else $error("add_result_buffer: capture into full FIFO");
`endif

endmodule

// File: tb/tb_add_result_buffer.sv
// tb_add_result_buffer: bench for add_result_buffer with N=32, LAT=2, DEPTH=4.
// It contains a pipelined adder stand-in with no reset and a queue-based
// reference model of the in-flight and buffered results. A hand-derived
// vector table covers the backpressure, simultaneous capture/pop and
// single-launch cases. Directed sequences cover reset, streaming and reset
// mid-stream, followed by random traffic.

module tb_add_result_buffer;

  localparam int N     = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  add_s;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N:0]    out_data;
  logic [LW-1:0] level;
`ifdef ADD_RESULT_BUFFER_STATS_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   res_cnt;
`endif

  logic [N-1:0]  op_a = '0;
  logic [N-1:0]  op_b = '0;

  always #5 clk = ~clk;

  add_result_buffer #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
`ifdef ADD_RESULT_BUFFER_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .res_cnt   (res_cnt)
`endif
  );

  // Adder stand-in: LAT register stages, no reset. Its output is valid LAT edges after launch.
  logic [N:0] add_pipe [LAT];
  always_ff @(posedge clk) begin
    add_pipe[0] <= {1'b0, op_a} + {1'b0, op_b};
    for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
  end
  assign {add_cout, add_s} = add_pipe[LAT-1];

  // ---------------- scoreboard / reference model ----------------
  logic [N:0] exp_q[$];    // results buffered, oldest first
  logic [N:0] pend_d[$];   // launched, not yet emerged
  int         pend_e[$];   // launch edge number of each pending result
  int         edge_n = 0;
  logic       exp_rdy = 1'b1;
  int         m_stall = 0;
  int         m_res = 0;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend_d.delete();
    pend_e.delete();
    exp_rdy = 1'b1;
    m_stall = 0;
    m_res = 0;
  endtask

  // Driver + model: apply one cycle of inputs, advance one edge, then compare with the model.
  task automatic step(input logic iv, input logic [N-1:0] a, input logic [N-1:0] b, input logic ordy);
    logic launch;
    logic pop;
    in_valid  = iv;
    op_a      = a;
    op_b      = b;
    out_ready = ordy;
    launch = iv && exp_rdy;
    pop    = (exp_q.size() != 0) && ordy;
    if (iv && !exp_rdy) m_stall++;
    if (pop) m_res++;
    @(posedge clk);
    edge_n++;
    if (pop) void'(exp_q.pop_front());
    if (pend_e.size() != 0 && pend_e[0] == edge_n - LAT) begin
      exp_q.push_back(pend_d.pop_front());
      void'(pend_e.pop_front());
    end
    if (launch) begin
      pend_d.push_back({1'b0, a} + {1'b0, b});
      pend_e.push_back(edge_n);
    end
    exp_rdy = (exp_q.size() + pend_e.size()) < DEPTH;
    #1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    chk("level", 64'(level), 64'(exp_q.size()));
    if (exp_q.size() != 0) chk("out_data", 64'(out_data), 64'(exp_q[0]));
`ifdef ADD_RESULT_BUFFER_STATS_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall % 65536));
    chk("res_cnt", 64'(res_cnt), 64'(m_res % 65536));
`endif
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          iv;
    logic          ordy;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          e_rdy;
    logic          e_vld;
    logic [LW-1:0] e_lvl;
    logic          chk_d;
    logic [N:0]    e_data;
  } vec_t;

  vec_t vecs[25];

  task automatic set_vec(input int i, input logic iv, input logic ordy, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic e_rdy, input logic e_vld,
                         input logic [LW-1:0] e_lvl, input logic chk_d, input logic [N:0] e_data);
    vecs[i] = '{iv, ordy, a, b, e_rdy, e_vld, e_lvl, chk_d, e_data};
  endtask

  initial begin
    int first_k;
    int last_k;
    int vcnt;
    int drops;

    // Backpressure: out_ready=0, continuous in_valid. Launches A..D, then in_ready falls and level fills to 4.
    set_vec(0,  1, 0, 32'h11, 0, 1, 0, 0, 1, 33'h0);
    set_vec(1,  1, 0, 32'h22, 0, 1, 0, 0, 1, 33'h0);
    set_vec(2,  1, 0, 32'h33, 0, 1, 1, 1, 1, 33'h11);
    set_vec(3,  1, 0, 32'h44, 0, 0, 1, 2, 1, 33'h11);
    set_vec(4,  1, 0, 32'h55, 0, 0, 1, 3, 1, 33'h11);
    set_vec(5,  1, 0, 32'h66, 0, 0, 1, 4, 1, 33'h11);
    set_vec(6,  1, 0, 32'h66, 0, 0, 1, 4, 1, 33'h11);
    // Drain in order, then pop while empty.
    set_vec(7,  0, 1, 32'h0,  0, 1, 1, 3, 1, 33'h22);
    set_vec(8,  0, 1, 32'h0,  0, 1, 1, 2, 1, 33'h33);
    set_vec(9,  0, 1, 32'h0,  0, 1, 1, 1, 1, 33'h44);
    set_vec(10, 0, 1, 32'h0,  0, 1, 0, 0, 0, 33'h0);
    set_vec(11, 0, 1, 32'h0,  0, 1, 0, 0, 0, 33'h0);
    // Build level 2, then capture and pop on the same edge.
    set_vec(12, 1, 0, 32'h77, 0, 1, 0, 0, 0, 33'h0);
    set_vec(13, 1, 0, 32'h88, 0, 1, 0, 0, 0, 33'h0);
    set_vec(14, 1, 0, 32'h99, 0, 1, 1, 1, 1, 33'h77);
    set_vec(15, 0, 0, 32'h0,  0, 1, 1, 2, 1, 33'h77);
    set_vec(16, 0, 1, 32'h0,  0, 1, 1, 2, 1, 33'h88);
    set_vec(17, 0, 1, 32'h0,  0, 1, 1, 1, 1, 33'h99);
    set_vec(18, 0, 1, 32'h0,  0, 1, 0, 0, 0, 33'h0);
    set_vec(19, 0, 1, 32'h0,  0, 1, 0, 0, 0, 33'h0);
    // Single launch with carry-out: one valid cycle, LAT edges after the launch edge.
    set_vec(20, 1, 1, 32'hFFFFFFFF, 32'h1, 1, 0, 0, 0, 33'h0);
    set_vec(21, 0, 1, 32'h0,  0, 1, 0, 0, 0, 33'h0);
    set_vec(22, 0, 1, 32'h0,  0, 1, 1, 1, 1, 33'h1_00000000);
    set_vec(23, 0, 1, 32'h0,  0, 1, 0, 0, 0, 33'h0);
    set_vec(24, 0, 1, 32'h0,  0, 1, 0, 0, 0, 33'h0);

    // Reset, then 10 idle cycles.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    model_clear();
    for (int k = 0; k < 10; k++) begin
      step(0, $urandom, $urandom, 1'($urandom_range(0, 1)));
      chk("idle_out_data", 64'(out_data), 64'd0);
    end

    // Vector table.
    for (int i = 0; i < 25; i++) begin
      step(vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_vld));
      chk($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].e_lvl));
      if (vecs[i].chk_d) chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].e_data));
    end

    // Stream 16 launches with out_ready held high.
    first_k = -1;
    last_k = -1;
    vcnt = 0;
    drops = 0;
    for (int k = 0; k < 16 + LAT + 4; k++) begin
      step(k < 16, $urandom, $urandom, 1'b1);
      if (k < 16 && !in_ready) drops++;
      if (out_valid) begin
        vcnt++;
        if (first_k < 0) first_k = k;
        last_k = k;
      end
    end
    chk("stream_ready_drops", 64'(drops), 64'd0);
    chk("stream_results", 64'(vcnt), 64'd16);
    chk("stream_first", 64'(first_k), 64'(LAT));
    chk("stream_contiguous", 64'(last_k - first_k + 1), 64'd16);

    // Reset mid-stream: two results buffered, two launches in flight.
    for (int k = 0; k < 4; k++) step(1, 32'h100 + k, 32'h0, 1'b0);
    chk("pre_rst_level", 64'(level), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
`ifdef ADD_RESULT_BUFFER_STATS_EN
    chk("mid_rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("mid_rst_res_cnt", 64'(res_cnt), 64'd0);
`endif
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step(0, 32'h0, 32'h0, 1'b1);
    step(1, 32'h1234, 32'h1, 1'b0);
    for (int k = 0; k < LAT; k++) step(0, 32'h0, 32'h0, 1'b0);
    chk("post_rst_first", 64'(out_data), 64'h1235);
    step(0, 32'h0, 32'h0, 1'b1);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0);
    end
    for (int k = 0; k < 8; k++) step(0, 32'h0, 32'h0, 1'b1);
    chk("final_empty", 64'(level), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
